// File: rtl/mem_port_arbiter_if.sv
// Shared memory port bundle: core requester, debug/loader requester and the memory itself.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_stall;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_halt;

  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_stall, core_rvalid, core_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_re, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_stall, core_rvalid, core_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_re, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single shared memory port arbiter between the core control path and a debug/loader port.
// Grants are combinational; read data is routed back to its owner one cycle after the grant.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_CORE_RUN = 4
) (
  input  logic               clock,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  localparam int N_REQ = 2;
  localparam int CORE  = 0;
  localparam int DBG   = 1;
  localparam int CNT_W = $clog2(MAX_CORE_RUN + 1);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_CORE_RUN);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

  logic [CNT_W-1:0]  run_cnt_reg, run_cnt_next;
  owner_t            rd_owner_reg, rd_owner_next;
  logic              run_at_max;
  logic              core_gnt, dbg_gnt;
  logic [N_REQ-1:0]  we_vec, gnt_vec, rvalid_vec;
  logic [ADDR_W-1:0] addr_arr  [N_REQ];
  logic [DATA_W-1:0] wdata_arr [N_REQ];
  logic [DATA_W-1:0] rdata_arr [N_REQ];

  assign we_vec           = {bus.dbg_we, bus.core_we};
  assign addr_arr[CORE]   = bus.core_addr;
  assign addr_arr[DBG]    = bus.dbg_addr;
  assign wdata_arr[CORE]  = bus.core_wdata;
  assign wdata_arr[DBG]   = bus.dbg_wdata;

  // Debug wins when the core is halted, when it is alone, or once the core used up its run.
  assign run_at_max = (run_cnt_reg == RUN_MAX);
  assign dbg_gnt    = ~reset & bus.dbg_req
                    & (bus.dbg_halt | ~bus.core_req | run_at_max);
  assign core_gnt   = ~reset & bus.core_req & ~bus.dbg_halt
                    & ~(bus.dbg_req & run_at_max);
  assign gnt_vec    = {dbg_gnt, core_gnt};

  // Grants are one-hot, so the port mux is a plain OR over the granted slot.
  always_comb begin
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_vec[i]) begin
        bus.mem_re    = ~we_vec[i];
        bus.mem_we    = we_vec[i];
        bus.mem_addr  = addr_arr[i];
        bus.mem_wdata = wdata_arr[i];
      end
    end
  end

  always_comb begin
    run_cnt_next  = run_cnt_reg;
    rd_owner_next = OWN_NONE;
    if (!bus.dbg_req || dbg_gnt) begin
      run_cnt_next = '0;
    end else if (core_gnt && !run_at_max) begin
      run_cnt_next = run_cnt_reg + CNT_W'(1);
    end
    if (core_gnt && !bus.core_we) begin
      rd_owner_next = OWN_CORE;
    end else if (dbg_gnt && !bus.dbg_we) begin
      rd_owner_next = OWN_DBG;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      run_cnt_reg  <= '0;
      rd_owner_reg <= OWN_NONE;
    end else begin
      run_cnt_reg  <= run_cnt_next;
      rd_owner_reg <= rd_owner_next;
    end
  end

  // Return path depends only on last cycle's owner, so it overlaps freely with new grants.
  // Gating with reset drops a read that was in flight when reset arrived.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_ret
      localparam owner_t SLOT_OWNER = (gi == CORE) ? OWN_CORE : OWN_DBG;
      assign rvalid_vec[gi] = ~reset & (rd_owner_reg == SLOT_OWNER);
      assign rdata_arr[gi]  = rvalid_vec[gi] ? bus.mem_rdata : '0;
    end
  endgenerate

  assign bus.core_gnt    = core_gnt;
  assign bus.core_stall  = bus.core_req & ~core_gnt;
  assign bus.core_rvalid = rvalid_vec[CORE];
  assign bus.core_rdata  = rdata_arr[CORE];
  assign bus.dbg_gnt     = dbg_gnt;
  assign bus.dbg_rvalid  = rvalid_vec[DBG];
  assign bus.dbg_rdata   = rdata_arr[DBG];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed cycles push expectations, a negedge
// monitor pops and compares per-cycle grant/port state and every returned read.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MCR = 4;
  localparam logic [1:0] GN = 2'b00;
  localparam logic [1:0] GC = 2'b01;
  localparam logic [1:0] GD = 2'b10;

  typedef struct {
    string       name;
    logic [1:0]  gnt;
    logic        stall;
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  rv;
  } cyc_t;

  typedef struct {
    logic [1:0]  owner;
    logic [31:0] data;
  } rd_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_CORE_RUN(MCR)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Memory echoes the read address; garbage otherwise so ungated rdata is visible.
  always @(posedge clock) begin
    bus.mem_rdata <= bus.mem_re ? bus.mem_addr : 32'hFFFF_FFFF;
  end

  cyc_t cyc_q[$];
  rd_t  rd_q[$];
  int   tests = 0;
  int   fails = 0;

  logic [31:0] cur_ca, cur_cd, cur_da, cur_dd;

  task automatic step(input string name, input bit rst, input bit cr, input bit cw,
                      input bit dr, input bit dw, input bit halt,
                      input logic [1:0] eg, input logic [1:0] erv);
    cyc_t e;
    @(posedge clock);
    #1;
    reset          = rst;
    bus.core_req   = cr;
    bus.core_we    = cw;
    bus.core_addr  = cur_ca;
    bus.core_wdata = cur_cd;
    bus.dbg_req    = dr;
    bus.dbg_we     = dw;
    bus.dbg_addr   = cur_da;
    bus.dbg_wdata  = cur_dd;
    bus.dbg_halt   = halt;
    e.name  = name;
    e.gnt   = eg;
    e.stall = cr & ~eg[0];
    e.re    = 1'b0;
    e.we    = 1'b0;
    e.addr  = '0;
    e.wdata = '0;
    e.rv    = erv;
    if (eg[0]) begin
      e.re = ~cw; e.we = cw; e.addr = cur_ca; e.wdata = cur_cd;
      if (!cw) rd_q.push_back('{owner: GC, data: cur_ca});
      cur_ca = cur_ca + 32'd4;
    end else if (eg[1]) begin
      e.re = ~dw; e.we = dw; e.addr = cur_da; e.wdata = cur_dd;
      if (!dw) rd_q.push_back('{owner: GD, data: cur_da});
      cur_da = cur_da + 32'd4;
    end
    if (rst) rd_q.delete();
    cyc_q.push_back(e);
  endtask

  initial begin : monitor
    cyc_t        e;
    rd_t         r;
    logic [1:0]  act_rv;
    logic [31:0] act_rd;
    forever begin
      @(negedge clock);
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        tests++;
        act_rv = {bus.dbg_rvalid, bus.core_rvalid};
        if ({bus.dbg_gnt, bus.core_gnt} !== e.gnt || bus.core_stall !== e.stall ||
            bus.mem_re !== e.re || bus.mem_we !== e.we || bus.mem_addr !== e.addr ||
            bus.mem_wdata !== e.wdata || act_rv !== e.rv ||
            (!e.rv[0] && bus.core_rdata !== '0) || (!e.rv[1] && bus.dbg_rdata !== '0)) begin
          fails++;
          $display("FAIL %s: got gnt=%b stall=%b re=%b we=%b addr=%h wdata=%h rv=%b crd=%h drd=%h; required gnt=%b stall=%b re=%b we=%b addr=%h wdata=%h rv=%b non-owner rdata=0",
                   e.name, {bus.dbg_gnt, bus.core_gnt}, bus.core_stall, bus.mem_re, bus.mem_we,
                   bus.mem_addr, bus.mem_wdata, act_rv, bus.core_rdata, bus.dbg_rdata,
                   e.gnt, e.stall, e.re, e.we, e.addr, e.wdata, e.rv);
        end else begin
          $display("[TB] cycle %s ok gnt=%b rv=%b addr=%h", e.name, e.gnt, act_rv, bus.mem_addr);
        end
        if (bus.core_rvalid || bus.dbg_rvalid) begin
          tests++;
          act_rd = bus.core_rvalid ? bus.core_rdata : bus.dbg_rdata;
          if (rd_q.size() == 0) begin
            fails++;
            $display("FAIL rdata_%s: got rvalid=%b data=%h; required no read return", e.name, act_rv, act_rd);
          end else begin
            r = rd_q.pop_front();
            if (act_rv !== r.owner || act_rd !== r.data) begin
              fails++;
              $display("FAIL rdata_%s: got owner=%b data=%h; required owner=%b data=%h",
                       e.name, act_rv, act_rd, r.owner, r.data);
            end else begin
              $display("[TB] read return %s owner=%b data=%h", e.name, act_rv, act_rd);
            end
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [1:0] eg, rv;
    reset = 1'b1;
    bus.core_req = 0; bus.core_we = 0; bus.core_addr = '0; bus.core_wdata = '0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0; bus.dbg_halt = 0;
    cur_ca = 32'h0; cur_cd = 32'h0; cur_da = 32'h40; cur_dd = 32'h0;

    // Reset with both requesting, then core wins at release.
    step("reset0",  1, 1, 0, 1, 0, 0, GN, GN);
    step("reset1",  1, 1, 0, 1, 0, 0, GN, GN);
    step("release", 0, 1, 0, 1, 0, 0, GC, GN);

    // Core-only back-to-back reads.
    cur_ca = 32'h0;
    step("core_rd0", 0, 1, 0, 0, 0, 0, GC, GC);
    step("core_rd1", 0, 1, 0, 0, 0, 0, GC, GC);
    step("core_rd2", 0, 1, 0, 0, 0, 0, GC, GC);
    step("idle0",    0, 0, 0, 0, 0, 0, GN, GC);

    // Contention: C,C,C,C,D repeating.
    cur_ca = 32'h100; cur_da = 32'h200;
    for (int i = 0; i < 11; i++) begin
      eg = (i % 5 == 4) ? GD : GC;
      rv = (i == 0) ? GN : (((i - 1) % 5 == 4) ? GD : GC);
      step("contend", 0, 1, 0, 1, 0, 0, eg, rv);
    end

    // Run counter clears whenever debug stops requesting.
    step("clr_a", 0, 1, 0, 0, 0, 0, GC, GC);
    for (int i = 0; i < 3; i++) step("clr_b", 0, 1, 0, 1, 0, 0, GC, GC);
    step("clr_c", 0, 1, 0, 0, 0, 0, GC, GC);
    for (int i = 0; i < 4; i++) step("clr_d", 0, 1, 0, 1, 0, 0, GC, GC);
    step("clr_e", 0, 1, 0, 1, 0, 0, GD, GC);
    step("idle1", 0, 0, 0, 0, 0, 0, GN, GD);

    // Alternating owners, pipelined.
    cur_ca = 32'h10; cur_da = 32'h20;
    step("alt_c", 0, 1, 0, 0, 0, 0, GC, GN);
    step("alt_d", 0, 0, 0, 1, 0, 0, GD, GC);
    step("alt_i", 0, 0, 0, 0, 0, 0, GN, GD);

    // Halt behaviour.
    cur_ca = 32'h30;
    step("halt_deny", 0, 1, 0, 0, 0, 1, GN, GN);
    cur_da = 32'h100; cur_dd = 32'hDEAD_BEEF;
    step("halt_dwr",  0, 1, 0, 1, 1, 1, GD, GN);
    step("halt_hold", 0, 1, 0, 0, 0, 1, GN, GN);
    cur_da = 32'h44;
    step("halt_drd",  0, 1, 0, 1, 0, 1, GD, GN);
    step("halt_rel",  0, 1, 0, 0, 0, 0, GC, GD);
    step("idle2",     0, 0, 0, 0, 0, 0, GN, GC);

    // Write leaves no stale rvalid.
    cur_ca = 32'h50; cur_cd = 32'h1234;
    step("core_wr", 0, 1, 1, 0, 0, 0, GC, GN);
    step("idle3",   0, 0, 0, 0, 0, 0, GN, GN);

    // Reset mid-read drops the pending return.
    cur_ca = 32'h60;
    step("rmr_rd",    0, 1, 0, 0, 0, 0, GC, GN);
    step("rmr_rst",   1, 0, 0, 0, 0, 0, GN, GN);
    step("rmr_after", 0, 0, 0, 0, 0, 0, GN, GN);
    step("idle4",     0, 0, 0, 0, 0, 0, GN, GN);

    @(negedge clock);
    #1;
    tests++;
    if (rd_q.size() != 0 || cyc_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: got %0d reads and %0d cycles outstanding; required 0 and 0",
               rd_q.size(), cyc_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
